// File: rtl/discharge_feedback_stat.sv
// Gap-state statistics: windowed mean voltage and short/open ratios published as a 32-bit
// feedback word with a one-cycle update strobe, plus a sustained short-circuit alarm.
module discharge_feedback_stat #(
  parameter int unsigned LOG2_WIN   = 16,
  parameter logic [15:0] V_OPEN_TH  = 16'd3000,
  parameter logic [15:0] V_SHORT_TH = 16'd500,
  parameter logic [15:0] I_TH       = 16'd200,
  parameter logic [15:0] SHORT_HOLD = 16'd100
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        sample_valid,
  input  logic [15:0] sample_current,
  input  logic [15:0] sample_voltage,
  output logic [31:0] feedback_data,
  output logic        feedback_update,
  output logic        short_alarm
);

  localparam int unsigned VsumW = 16 + LOG2_WIN;
  localparam int unsigned CntW  = LOG2_WIN + 1;

  typedef enum logic {StIdle, StAccum} state_e;

  state_e              state_q, state_d;
  logic [VsumW-1:0]    vsum_q, vsum_d;
  logic [CntW-1:0]     scnt_q, scnt_d;
  logic [CntW-1:0]     ocnt_q, ocnt_d;
  logic [LOG2_WIN-1:0] wcnt_q, wcnt_d;
  logic [31:0]         fb_q, fb_d;
  logic                upd_q, upd_d;
  logic [15:0]         run_q, run_d;
  logic                alarm_q, alarm_d;

  logic                is_short, is_open, accept, win_end;
  logic [VsumW-1:0]    vsum_fin;
  logic [CntW-1:0]     scnt_fin, ocnt_fin;

  function automatic logic [7:0] sat_ratio(input logic [CntW-1:0] cnt);
    logic [8:0] r;
    r = cnt[LOG2_WIN -: 9];
    return r[8] ? 8'hFF : r[7:0];
  endfunction

  assign is_short = (sample_voltage < V_SHORT_TH) && (sample_current >= I_TH);
  assign is_open  = (sample_voltage > V_OPEN_TH) && (sample_current < I_TH);

  // The window-ending sample still counts when enable drops in the same cycle.
  assign accept  = sample_valid && (enable || ((state_q == StAccum) && (&wcnt_q)));
  assign win_end = accept && (&wcnt_q);

  assign vsum_fin = vsum_q + VsumW'(sample_voltage);
  assign scnt_fin = scnt_q + CntW'(is_short);
  assign ocnt_fin = ocnt_q + CntW'(is_open);

  always_comb begin
    state_d = state_q;
    vsum_d  = vsum_q;
    scnt_d  = scnt_q;
    ocnt_d  = ocnt_q;
    wcnt_d  = wcnt_q;
    fb_d    = fb_q;
    upd_d   = 1'b0;
    run_d   = run_q;

    if (accept) begin
      vsum_d = vsum_fin;
      scnt_d = scnt_fin;
      ocnt_d = ocnt_fin;
      wcnt_d = wcnt_q + LOG2_WIN'(1);
    end

    if (win_end) begin
      fb_d   = {vsum_fin[VsumW-1 -: 16], sat_ratio(scnt_fin), sat_ratio(ocnt_fin)};
      upd_d  = 1'b1;
      vsum_d = '0;
      scnt_d = '0;
      ocnt_d = '0;
    end

    if (enable) begin
      state_d = StAccum;
    end else begin
      state_d = StIdle;
      vsum_d  = '0;
      scnt_d  = '0;
      ocnt_d  = '0;
      wcnt_d  = '0;
    end

    if (!enable) begin
      run_d = '0;
    end else if (sample_valid) begin
      run_d = is_short ? ((&run_q) ? run_q : run_q + 16'd1) : 16'd0;
    end
    alarm_d = (run_d != 16'd0) && (run_d >= SHORT_HOLD);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      vsum_q  <= '0;
      scnt_q  <= '0;
      ocnt_q  <= '0;
      wcnt_q  <= '0;
      fb_q    <= '0;
      upd_q   <= 1'b0;
      run_q   <= '0;
      alarm_q <= 1'b0;
    end else begin
      state_q <= state_d;
      vsum_q  <= vsum_d;
      scnt_q  <= scnt_d;
      ocnt_q  <= ocnt_d;
      wcnt_q  <= wcnt_d;
      fb_q    <= fb_d;
      upd_q   <= upd_d;
      run_q   <= run_d;
      alarm_q <= alarm_d;
    end
  end

  assign feedback_data   = fb_q;
  assign feedback_update = upd_q;
  assign short_alarm     = alarm_q;

endmodule
